// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four requesters sharing one 4:1 mux.
// Holds a grant until done, request drop, or the hold limit while others wait.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [1:0]       ptr_q, ptr_d;

    logic [1:0] end_ptr;
    logic [2:0] pick_idle;
    logic [2:0] pick_end;
    logic       end_done;
    logic       end_drop;
    logic       end_force;

    // Returns {found, index}; the requester closest above ptr (mod 4) wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign end_ptr   = sel_q + 2'd1;
    assign pick_idle = rr_pick(req, ptr_q);
    assign pick_end  = rr_pick(req, end_ptr);
    assign end_done  = done;
    assign end_drop  = !req[sel_q];
    assign end_force = (MAX_HOLD > 0) && (hold_q == HOLD_LAST) && ((req & ~gnt_q) != 4'b0000);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick_idle[1:0];
                    sel_d   = pick_idle[1:0];
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end else begin
                    gnt_d  = 4'b0000;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                if (end_done || end_drop || end_force) begin
                    ptr_d     = end_ptr;
                    // Only a pure hold-limit expiry counts as a forced end.
                    timeout_d = end_force && !end_done && !end_drop;
                    hold_d    = '0;
                    if (pick_end[2]) begin
                        gnt_d  = 4'b0001 << pick_end[1:0];
                        sel_d  = pick_end[1:0];
                        busy_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end else if ((MAX_HOLD > 0) && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            ptr_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4 (MAX_HOLD=4): the driver queues hand-computed
// expected outputs per cycle, and a monitor pops and compares after each edge.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int         n_checks = 0;
    int         n_fail   = 0;
    string      tag      = "init";
    logic [7:0] sb[$];

    rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic [3:0] r, input logic d, input logic [3:0] eg,
                        input logic [1:0] es, input logic eb, input logic et);
        @(negedge clk);
        req  = r;
        done = d;
        sb.push_back({eg, es, eb, et});
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({gnt, sel, busy, timeout} !== 8'b0) begin
            n_fail++;
            $display("FAIL %s: gnt=%b sel=%0d busy=%b timeout=%b, required all zero",
                     name, gnt, sel, busy, timeout);
        end
    endtask

    // Monitor: compare every registered output once per clock when something is queued.
    initial begin
        logic [7:0] exp_v;
        logic [7:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                act_v = {gnt, sel, busy, timeout};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s @%0t: gnt/sel/busy/timeout got %b/%0d/%b/%b required %b/%0d/%b/%b",
                             tag, $time, act_v[7:4], act_v[3:2], act_v[1], act_v[0],
                             exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #1;
        check_zero("reset_start");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tag = "single";
        for (int i = 0; i < 5; i++) step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);

        tag = "reset_mid";
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

        tag = "rotation";
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Requester 3 takes and drops a grant so the pointer returns to 0.
        tag = "ptr_setup";
        step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);

        tag = "timeout";
        for (int i = 0; i < 4; i++) step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

        tag = "no_contention";
        for (int i = 0; i < 20; i++) step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

        tag = "drop";
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);

        tag = "regrant_clears_hold";
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);

        tag = "done_in_idle";
        step(4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left in scoreboard, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
